apb_master: RTL and testbench

- APB requester driving the PCLK/PRESETn APB bus that our APB-to-I2C slave bridge sits on.
- Takes single read/write commands from a valid/ready command port and runs IDLE -> SETUP -> ACCESS APB transfers.
- Returns the read data and the error/timeout status on a one-cycle response strobe.
- Used by the bench-side CPU model and by the future on-chip config sequencer that programs the I2C bridge.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_wait_timer.sv | 34 +++
 rtl/apb_master.sv | 131 +++++++++++++
 tb/tb_apb_master.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester and the I2C bridge register map.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [31:0] APB_ADDR_TX_FIFO     = 32'd0;
  localparam logic [31:0] APB_ADDR_RX_FIFO     = 32'd4;
  localparam logic [31:0] APB_ADDR_I2C_CONFIG  = 32'd8;
  localparam logic [31:0] APB_ADDR_I2C_TIMEOUT = 32'd12;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating count of PREADY-low ACCESS samples; expired flags that the next low sample is the last allowed.
// Purely counting, no backpressure; TIMEOUT_CYCLES=0 keeps expired low forever.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES) : '1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Compared against the value before the edge, so it fires on the TIMEOUT_CYCLES-th low sample.
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: one command per IDLE->SETUP->ACCESS transfer, registered one-cycle response strobe.
// Min 3 cycles accept-to-accept; CMD_READY low outside IDLE, PREADY wait states stretch ACCESS up to the timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERROR,
  output logic              RSP_TIMEOUT,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_e        state, state_nxt;
  logic              psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt;
  logic              rsp_valid_nxt, rsp_error_nxt, rsp_timeout_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;
  logic              tmr_expired;

  assign CMD_READY = (state == IDLE) & PRESETn;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .clr    (state == SETUP),
    .inc    ((state == ACCESS) && !PREADY),
    .expired(tmr_expired)
  );

  always_comb begin
    state_nxt       = state;
    psel_nxt        = PSELx;
    penable_nxt     = PENABLE;
    pwrite_nxt      = PWRITE;
    paddr_nxt       = PADDR;
    pwdata_nxt      = PWDATA;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = RSP_RDATA;
    rsp_error_nxt   = RSP_ERROR;
    rsp_timeout_nxt = RSP_TIMEOUT;
    case (state)
      IDLE: begin
        if (CMD_VALID && CMD_READY) begin
          pwrite_nxt  = CMD_WRITE;
          paddr_nxt   = CMD_ADDR;
          pwdata_nxt  = CMD_WDATA;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        // A ready sample always wins over a timeout landing on the same edge.
        if (PREADY) begin
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          state_nxt       = IDLE;
          rsp_valid_nxt   = 1'b1;
          rsp_error_nxt   = PSLVERR;
          rsp_timeout_nxt = 1'b0;
          rsp_rdata_nxt   = PWRITE ? '0 : PRDATA;
        end else if (tmr_expired) begin
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          state_nxt       = IDLE;
          rsp_valid_nxt   = 1'b1;
          rsp_error_nxt   = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_rdata_nxt   = '0;
        end
      end
      default: begin
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      RSP_VALID   <= 1'b0;
      RSP_RDATA   <= '0;
      RSP_ERROR   <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
    end else begin
      state       <= state_nxt;
      PSELx       <= psel_nxt;
      PENABLE     <= penable_nxt;
      PWRITE      <= pwrite_nxt;
      PADDR       <= paddr_nxt;
      PWDATA      <= pwdata_nxt;
      RSP_VALID   <= rsp_valid_nxt;
      RSP_RDATA   <= rsp_rdata_nxt;
      RSP_ERROR   <= rsp_error_nxt;
      RSP_TIMEOUT <= rsp_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: scripted APB slave, expected-response queue and an independent response monitor.
module tb_apb_master;
  import apb_pkg::*;

  localparam int TMO = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        CMD_VALID, CMD_READY, CMD_WRITE;
  logic [31:0] CMD_ADDR, CMD_WDATA;
  logic        RSP_VALID, RSP_ERROR, RSP_TIMEOUT;
  logic [31:0] RSP_RDATA;
  logic        PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERROR(RSP_ERROR),
    .RSP_TIMEOUT(RSP_TIMEOUT),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          waits;  // PREADY-low ACCESS samples before the slave answers
  } cmd_t;

  cmd_t slave_q[$];
  cmd_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   psel_cnt = 0;
  int   en_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the slave's answer passes through unless it stalls for TMO or more samples.
  function automatic logic [33:0] model(input cmd_t c);
    if (c.waits >= TMO) return {1'b1, 1'b1, 32'h0};
    return {1'b0, c.err, (c.write ? 32'h0 : c.rdata)};
  endfunction

  // Scripted APB slave; PSLVERR is deliberately 1 during wait states.
  initial begin
    cmd_t cur;
    bit   active;
    int   k;
    active = 0; k = 0;
    PREADY = 1'b0; PRDATA = 32'h0; PSLVERR = 1'b0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        PREADY = 1'b0; active = 0;
      end else if (PSELx && !PENABLE) begin
        chk("slave_q_nonempty", 32'(slave_q.size() != 0), 32'd1);
        if (slave_q.size() != 0) cur = slave_q.pop_front();
        active = 1; k = 0; psel_cnt = 1; en_cnt = 0;
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'b1;
        chk("setup_paddr", PADDR, cur.addr);
        chk("setup_pwrite", 32'(PWRITE), 32'(cur.write));
        chk("setup_pwdata", PWDATA, cur.wdata);
      end else if (PSELx && PENABLE && active) begin
        psel_cnt++; en_cnt++;
        if (k >= cur.waits) begin
          PREADY = 1'b1; PRDATA = cur.rdata; PSLVERR = cur.err;
        end else begin
          PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'b1;
        end
        k++;
        chk("access_paddr", PADDR, cur.addr);
        chk("access_pwrite", 32'(PWRITE), 32'(cur.write));
        chk("access_pwdata", PWDATA, cur.wdata);
      end else begin
        if (PENABLE) chk("penable_without_psel", 32'(PENABLE), 32'd0);
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'b0;
      end
    end
  end

  // Response monitor: pops the oldest expectation on every strobe.
  initial begin
    cmd_t        c;
    logic [33:0] e;
    logic [31:0] last_rdata;
    logic        last_err, last_tmo;
    bit          have_last;
    int          exp_en;
    have_last = 0; last_rdata = 0; last_err = 0; last_tmo = 0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        have_last = 0;
      end else if (RSP_VALID) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          c = exp_q.pop_front();
          e = model(c);
          exp_en = (c.waits >= TMO) ? TMO : c.waits + 1;
          chk("rsp_rdata", RSP_RDATA, e[31:0]);
          chk("rsp_error", 32'(RSP_ERROR), 32'(e[32]));
          chk("rsp_timeout", 32'(RSP_TIMEOUT), 32'(e[33]));
          chk("penable_cycles", 32'(en_cnt), 32'(exp_en));
          chk("psel_cycles", 32'(psel_cnt), 32'(exp_en + 1));
        end
        last_rdata = RSP_RDATA; last_err = RSP_ERROR; last_tmo = RSP_TIMEOUT;
        have_last = 1;
      end else if (have_last) begin
        chk("hold_rdata", RSP_RDATA, last_rdata);
        chk("hold_error", 32'(RSP_ERROR), 32'(last_err));
        chk("hold_timeout", 32'(RSP_TIMEOUT), 32'(last_tmo));
        have_last = 0;
      end
    end
  end

  // Presents a command and returns the accept time; CMD_VALID is left high for the caller.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input bit e, input int waits, output time t_acc);
    cmd_t c;
    int   n;
    t_acc = 0;
    c.write = w; c.addr = a; c.wdata = wd; c.rdata = rd; c.err = e; c.waits = waits;
    @(negedge PCLK);
    CMD_WRITE = w; CMD_ADDR = a; CMD_WDATA = wd; CMD_VALID = 1'b1;
    n = 0;
    while (!CMD_READY && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    if (!CMD_READY) begin
      chk("accept_timeout", 32'd0, 32'd1);
      CMD_VALID = 1'b0;
      return;
    end
    @(posedge PCLK);
    t_acc = $time;
    slave_q.push_back(c);
    exp_q.push_back(c);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(negedge PCLK);
  endtask

  function automatic int pick_waits();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 1;
      2:       return int'($urandom_range(2, 6));
      3:       return TMO - 1;
      4:       return TMO;
      default: return int'($urandom_range(TMO + 1, TMO + 4));
    endcase
  endfunction

  initial begin
    time t0, t1, t2;
    int  n;
    logic [31:0] addrs [4];
    addrs[0] = APB_ADDR_TX_FIFO; addrs[1] = APB_ADDR_RX_FIFO;
    addrs[2] = APB_ADDR_I2C_CONFIG; addrs[3] = APB_ADDR_I2C_TIMEOUT;

    PRESETn = 1'b0; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0;
    #3;
    chk("rst_psel", 32'(PSELx), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rsp_rdata", RSP_RDATA, 32'd0);
    chk("rst_rsp_error", 32'(RSP_ERROR), 32'd0);
    chk("rst_rsp_timeout", 32'(RSP_TIMEOUT), 32'd0);
    chk("rst_cmd_ready", 32'(CMD_READY), 32'd0);
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("cmd_ready_after_rst", 32'(CMD_READY), 32'd1);

    // Zero-wait write, stalled read, slave error, timeout and its boundary.
    issue(1, APB_ADDR_I2C_CONFIG, 32'h0000_1234, 32'hDEAD_BEEF, 0, 0, t0); CMD_VALID = 1'b0; drain();
    issue(0, APB_ADDR_RX_FIFO, 32'h1111_2222, 32'hA5A5_5A5A, 0, 3, t0);    CMD_VALID = 1'b0; drain();
    issue(1, APB_ADDR_TX_FIFO, 32'h0000_00C3, 32'h0, 1, 2, t0);            CMD_VALID = 1'b0; drain();
    issue(0, APB_ADDR_I2C_TIMEOUT, 32'h0, 32'h1357_9BDF, 0, 40, t0);       CMD_VALID = 1'b0; drain();
    issue(0, APB_ADDR_RX_FIFO, 32'h0, 32'h0BAD_F00D, 0, TMO - 1, t0);      CMD_VALID = 1'b0; drain();

    // CMD_VALID held across three zero-wait commands.
    issue(1, APB_ADDR_TX_FIFO, 32'h0000_0001, 32'h0, 0, 0, t0);
    issue(0, APB_ADDR_RX_FIFO, 32'h0000_0002, 32'hCAFE_0001, 0, 0, t1);
    issue(1, APB_ADDR_I2C_CONFIG, 32'h0000_0003, 32'h0, 1, 0, t2);
    CMD_VALID = 1'b0;
    chk("accept_spacing_1", 32'(t1 - t0), 32'd30);
    chk("accept_spacing_2", 32'(t2 - t1), 32'd30);
    drain();

    // Reset asserted while the slave is stalling.
    issue(0, APB_ADDR_RX_FIFO, 32'h0, 32'h7777_7777, 0, 10, t0);
    CMD_VALID = 1'b0;
    n = 0;
    while (!PENABLE && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    chk("reached_access", 32'(PENABLE), 32'd1);
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    chk("midrst_psel", 32'(PSELx), 32'd0);
    chk("midrst_penable", 32'(PENABLE), 32'd0);
    chk("midrst_rsp_valid", 32'(RSP_VALID), 32'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("midrst_cmd_ready", 32'(CMD_READY), 32'd1);
    repeat (4) @(negedge PCLK);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom), ($urandom_range(0, 3) == 0) ? 32'($urandom) : addrs[$urandom_range(0, 3)],
            32'($urandom), 32'($urandom), 1'($urandom_range(0, 3) == 0), pick_waits(), t0);
      if ($urandom_range(0, 1) == 0) begin
        CMD_VALID = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge PCLK);
      end
    end
    CMD_VALID = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
